// File: rtl/trainer_pkg.sv
// Shared types and constants for the trainer-kit lab core.
package trainer_pkg;

  typedef enum logic [1:0] {
    MODE_GATE  = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_SHIFT = 2'd2,
    MODE_LFSR  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    G_AND  = 3'd0,
    G_OR   = 3'd1,
    G_NOTA = 3'd2,
    G_NAND = 3'd3,
    G_NOR  = 3'd4,
    G_XOR  = 3'd5,
    G_XNOR = 3'd6,
    G_PASS = 3'd7
  } gate_e;

  typedef enum logic [1:0] {
    DB_IDLE    = 2'd0,
    DB_WAIT_HI = 2'd1,
    DB_HELD    = 2'd2,
    DB_WAIT_LO = 2'd3
  } dbnc_state_e;

  // Fibonacci feedback masks (bit i set = tap on register bit i), maximal length per width.
  localparam logic [7:0] LFSR_TAPS [2:8] = '{8'h03, 8'h06, 8'h0C, 8'h14, 8'h30, 8'h60, 8'hB8};

endpackage

// File: rtl/trainer_debounce.sv
// Step-button conditioner: 2-FF synchroniser feeding a debounce FSM that emits
// a single one-cycle pulse per accepted press, however long the button is held.
module trainer_debounce
  import trainer_pkg::*;
#(
  parameter int DEBOUNCE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic step_btn,
  output logic step_pulse
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE);

  logic          sync1_q, sync2_q;
  dbnc_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          pulse_q, pulse_d;

  assign cnt_inc    = cnt_q + CW'(1);
  assign step_pulse = pulse_q;

  // Synchroniser, FSM state, stability counter and registered pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= step_btn;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // Next state: a level is accepted only after DEBOUNCE consecutive stable cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      DB_IDLE: begin
        if (sync2_q) state_d = DB_WAIT_HI;
        else         state_d = DB_IDLE;
      end
      DB_WAIT_HI: begin
        if (!sync2_q) begin
          state_d = DB_IDLE;
        end else if (cnt_inc == CNT_DONE) begin
          state_d = DB_HELD;
        end else begin
          state_d = DB_WAIT_HI;
          cnt_d   = cnt_inc;
        end
      end
      DB_HELD: begin
        if (!sync2_q) state_d = DB_WAIT_LO;
        else          state_d = DB_HELD;
      end
      DB_WAIT_LO: begin
        if (sync2_q) begin
          state_d = DB_HELD;
        end else if (cnt_inc == CNT_DONE) begin
          state_d = DB_IDLE;
        end else begin
          state_d = DB_WAIT_LO;
          cnt_d   = cnt_inc;
        end
      end
      default: begin
        state_d = DB_IDLE;
      end
    endcase
  end

  // Output: pulse only on the WAIT_HI -> HELD acceptance, so a held button gives one step.
  always_comb begin
    if (state_q == DB_WAIT_HI && state_d == DB_HELD) pulse_d = 1'b1;
    else                                             pulse_d = 1'b0;
  end

endmodule

// File: rtl/trainer_seq_lab.sv
// Trainer-kit lab core: combinational gate lab plus counter / shift / LFSR labs
// advanced by a debounced single step or a prescaled free-run tick.
module trainer_seq_lab
  import trainer_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1000,
  parameter int DEBOUNCE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [2:0]       gate_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             load,
  input  logic             run,
  input  logic             dir,
  input  logic             ser_in,
  input  logic             step_btn,
  output logic [WIDTH-1:0] result,
  output logic             flag,
  output logic             tick_seen
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] TAPS       = WIDTH'(LFSR_TAPS[WIDTH]);

  logic [PW-1:0]    presc_q, presc_d;
  mode_e            mode_q, mode_s;
  logic [WIDTH-1:0] res_q, res_d;
  logic             flag_q, flag_d;
  logic             tick_seen_q, tick_seen_d;
  logic             step_pulse, presc_tick, tick, mode_chg;
  logic [WIDTH-1:0] gate_w, lfsr_w;
  logic             cnt_flag;

  trainer_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .step_btn  (step_btn),
    .step_pulse(step_pulse)
  );

  assign mode_s    = mode_e'(mode);
  assign mode_chg  = (mode_s != mode_q);
  assign tick      = run ? presc_tick : step_pulse;
  assign result    = res_q;
  assign tick_seen = tick_seen_q;
  // Terminal count depends on the live dir, so it is decoded from the registered count.
  assign cnt_flag  = dir ? (&res_q) : ~(|res_q);
  assign flag      = (mode_q == MODE_COUNT) ? cnt_flag : flag_q;

  // Free-run prescaler; parked at zero while single-stepping so run starts a full period.
  always_comb begin
    presc_d    = '0;
    presc_tick = 1'b0;
    if (run) begin
      if (presc_q == PRESC_LAST) begin
        presc_tick = 1'b1;
        presc_d    = '0;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      presc_d = '0;
    end
  end

  // Gate lab operator decode.
  always_comb begin
    case (gate_e'(gate_sel))
      G_AND:   gate_w = op_a & op_b;
      G_OR:    gate_w = op_a | op_b;
      G_NOTA:  gate_w = ~op_a;
      G_NAND:  gate_w = ~(op_a & op_b);
      G_NOR:   gate_w = ~(op_a | op_b);
      G_XOR:   gate_w = op_a ^ op_b;
      G_XNOR:  gate_w = ~(op_a ^ op_b);
      G_PASS:  gate_w = op_a;
      default: gate_w = op_a;
    endcase
  end

  // LFSR step with escape from the all-zero lockup state.
  always_comb begin
    if (res_q == '0) lfsr_w = WIDTH'(1);
    else             lfsr_w = {res_q[WIDTH-2:0], ^(res_q & TAPS)};
  end

  // Lab datapath: mode change beats load beats tick.
  always_comb begin
    res_d       = res_q;
    flag_d      = flag_q;
    tick_seen_d = tick & ~mode_chg;
    if (mode_chg) begin
      res_d  = '0;
      flag_d = 1'b0;
    end else begin
      case (mode_s)
        MODE_GATE: begin
          res_d  = gate_w;
          flag_d = |gate_w;
        end
        MODE_COUNT: begin
          flag_d = 1'b0;
          if (load)      res_d = op_a;
          else if (tick) res_d = dir ? (res_q + WIDTH'(1)) : (res_q - WIDTH'(1));
          else           res_d = res_q;
        end
        MODE_SHIFT: begin
          if (load) begin
            res_d  = op_a;
            flag_d = 1'b0;
          end else if (tick) begin
            if (dir) begin
              res_d  = {res_q[WIDTH-2:0], ser_in};
              flag_d = res_q[WIDTH-1];
            end else begin
              res_d  = {ser_in, res_q[WIDTH-1:1]};
              flag_d = res_q[0];
            end
          end else begin
            res_d = res_q;
          end
        end
        MODE_LFSR: begin
          if (load) begin
            res_d  = op_a;
            flag_d = op_a[0];
          end else if (tick) begin
            res_d  = lfsr_w;
            flag_d = lfsr_w[0];
          end else begin
            res_d = res_q;
          end
        end
        default: begin
          res_d  = '0;
          flag_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q     <= '0;
      mode_q      <= MODE_GATE;
      res_q       <= '0;
      flag_q      <= 1'b0;
      tick_seen_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      mode_q      <= mode_s;
      res_q       <= res_d;
      flag_q      <= flag_d;
      tick_seen_q <= tick_seen_d;
    end
  end

endmodule

// File: tb/tb_trainer_seq_lab.sv
// Scoreboard bench for trainer_seq_lab (WIDTH=4, PRESCALE=4, DEBOUNCE=16).
// Stimulus pushes expectations; a monitor pops tick expectations on tick_seen and
// timed expectations at their due cycle.
module tb_trainer_seq_lab;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [2:0] gate_sel;
  logic [3:0] op_a, op_b;
  logic       load, run, dir, ser_in, step_btn;
  logic [3:0] result;
  logic       flag, tick_seen;

  always #5 clk = ~clk;

  trainer_seq_lab #(.WIDTH(4), .PRESCALE(4), .DEBOUNCE(16)) dut (
    .clk(clk), .rst(rst), .mode(mode), .gate_sel(gate_sel), .op_a(op_a), .op_b(op_b),
    .load(load), .run(run), .dir(dir), .ser_in(ser_in), .step_btn(step_btn),
    .result(result), .flag(flag), .tick_seen(tick_seen)
  );

  typedef struct {
    int         cyc;
    logic [3:0] res;
    logic       flg;
    string      name;
  } exp_t;

  exp_t tq[$];
  exp_t sq[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [3:0] gate_tab [8] = '{4'b1000, 4'b1110, 4'b0011, 4'b0111,
                               4'b0001, 4'b0110, 4'b1001, 4'b1100};
  logic [3:0] lfsr_tab [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110,
                                4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111, 4'b1111,
                                4'b1110, 4'b1100, 4'b1000, 4'b0001};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [3:0] ar, logic af, logic [3:0] er, logic ef);
    n_chk++;
    if (ar === er && af === ef) n_pass++;
    else $display("FAIL %s: got result=%b flag=%b, expected result=%b flag=%b", nm, ar, af, er, ef);
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_tick(logic [3:0] r, logic f, string nm);
    exp_t e;
    e.cyc = 0; e.res = r; e.flg = f; e.name = nm;
    tq.push_back(e);
  endtask

  task automatic exp_at(int d, logic [3:0] r, logic f, string nm);
    exp_t e;
    e.cyc = cyc + d; e.res = r; e.flg = f; e.name = nm;
    sq.push_back(e);
  endtask

  task automatic do_load(logic [3:0] v, logic f, string nm);
    op_a = v;
    load = 1'b1;
    exp_at(1, v, f, nm);
    step(1);
    load = 1'b0;
  endtask

  task automatic press(int hold, int rel);
    step_btn = 1'b1;
    step(hold);
    step_btn = 1'b0;
    step(rel);
  endtask

  // Monitor: sample one time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (tick_seen === 1'b1) begin
        if (tq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_tick: got tick_seen=1 result=%b, expected no tick", result);
        end else begin
          e = tq.pop_front();
          chk(e.name, result, flag, e.res, e.flg);
        end
      end
      while (sq.size() > 0 && sq[0].cyc <= cyc) begin
        e = sq.pop_front();
        chk(e.name, result, flag, e.res, e.flg);
      end
    end
  end

  // Stimulus.
  initial begin
    rst = 1'b1; mode = 2'd0; gate_sel = 3'd0; op_a = 4'h0; op_b = 4'h0;
    load = 1'b0; run = 1'b0; dir = 1'b0; ser_in = 1'b0; step_btn = 1'b0;
    step(3);
    chk("reset_out", result, flag, 4'h0, 1'b0);
    chk("reset_tick_seen", {3'b000, tick_seen}, 1'b0, 4'h0, 1'b0);
    rst = 1'b0;
    step(2);

    // 1: gate sweep, one clock latency each.
    op_a = 4'b1100; op_b = 4'b1010;
    for (int s = 0; s < 8; s++) begin
      gate_sel = 3'(s);
      exp_at(1, gate_tab[s], |gate_tab[s], $sformatf("gate_sel%0d", s));
      step(1);
    end

    // 2: free-run counter, tick every 4 clocks.
    mode = 2'd1; dir = 1'b1;
    step(1);
    do_load(4'hE, 1'b0, "count_load_E");
    run = 1'b1;
    exp_tick(4'hF, 1'b1, "count_up_F");
    exp_tick(4'h0, 1'b0, "count_up_0");
    exp_tick(4'h1, 1'b0, "count_up_1");
    step(12);
    dir = 1'b0;
    exp_tick(4'h0, 1'b1, "count_dn_0");
    exp_tick(4'hF, 1'b0, "count_dn_F");
    step(8);
    run = 1'b0;
    step(2);

    // 3: debounced single steps with bounce on press and release.
    dir = 1'b1;
    do_load(4'h0, 1'b0, "count_load_0");
    exp_tick(4'h1, 1'b0, "step_pulse1");
    for (int i = 0; i < 3; i++) press(5, 3);
    step_btn = 1'b1;
    step(40);
    for (int i = 0; i < 3; i++) begin
      step_btn = 1'b0; step(5);
      step_btn = 1'b1; step(3);
    end
    step_btn = 1'b0;
    step(40);
    exp_tick(4'h2, 1'b0, "step_pulse2");
    press(40, 40);

    // 4: shift left with serial zero.
    mode = 2'd2;
    step(1);
    do_load(4'b1001, 1'b0, "shift_load");
    dir = 1'b1; ser_in = 1'b0;
    exp_tick(4'b0010, 1'b1, "shift1");
    press(30, 30);
    exp_tick(4'b0100, 1'b0, "shift2");
    press(30, 30);

    // 5: LFSR from zero, full period of 15 after lockup escape.
    mode = 2'd3;
    step(1);
    do_load(4'h0, 1'b0, "lfsr_load_0");
    for (int i = 0; i < 16; i++) exp_tick(lfsr_tab[i], lfsr_tab[i][0], $sformatf("lfsr%0d", i));
    run = 1'b1;
    step(64);
    run = 1'b0;
    step(2);

    // 6a: mode change coincident with a prescaler tick at count 5.
    mode = 2'd1; dir = 1'b1;
    step(1);
    do_load(4'h5, 1'b0, "count_load_5");
    run = 1'b1;
    step(3);
    mode = 2'd2;
    exp_at(1, 4'h0, 1'b0, "modechg_clear");
    step(1);
    run = 1'b0;
    step(2);

    // 6b: reset while the debouncer is in WAIT_HI.
    step_btn = 1'b1;
    step(8);
    rst = 1'b1;
    #1;
    chk("rst_mid_out", result, flag, 4'h0, 1'b0);
    chk("rst_mid_tick_seen", {3'b000, tick_seen}, 1'b0, 4'h0, 1'b0);
    step_btn = 1'b0;
    step(3);
    chk("rst_hold_out", result, flag, 4'h0, 1'b0);
    rst = 1'b0;
    step(40);
    exp_at(1, 4'h0, 1'b0, "post_rst_out");
    step(3);

    n_chk++;
    if (tq.size() == 0) n_pass++;
    else $display("FAIL tick_queue_drained: got %0d pending ticks, expected 0", tq.size());
    n_chk++;
    if (sq.size() == 0) n_pass++;
    else $display("FAIL timed_queue_drained: got %0d pending checks, expected 0", sq.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
